// File: rtl/softmax_pkg.sv
// softmax_pkg: shared score format and index-width helper for the softmax front end
package softmax_pkg;
  localparam int DATA_W = 16;
  localparam logic signed [DATA_W-1:0] NEG_MIN = 16'sh8000;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/softmax_row_packer_lane_mask.sv
// softmax_row_packer_lane_mask: marks lanes past the closing index (and past row_idx under CAUSAL_MASK_EN)
module softmax_row_packer_lane_mask
  import softmax_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [idx_w(N)-1:0] close_idx,
`ifdef CAUSAL_MASK_EN
  input  logic [idx_w(N)-1:0] row_idx,
`endif
  output logic [N-1:0]        mask
);
  localparam int IDX_W = idx_w(N);
  for (genvar k = 0; k < N; k++) begin : g_lane
`ifdef CAUSAL_MASK_EN
    assign mask[k] = (IDX_W'(k) > close_idx) || (IDX_W'(k) > row_idx);
`else
    assign mask[k] = IDX_W'(k) > close_idx;
`endif
  end
endmodule

// File: rtl/softmax_row_packer.sv
// softmax_row_packer: packs a score stream into padded N-lane rows for the softmax.
// CAUSAL_MASK_EN adds a wrapping row counter that also masks lanes beyond the current row index.
module softmax_row_packer
  import softmax_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic                valid_out,
  output logic [N*DATA_W-1:0] out_x_flat,
  output logic                err_len
);
  localparam int CNT_W = $clog2(N) + 1;
  localparam int IDX_W = idx_w(N);
  logic [CNT_W-1:0]    fill_cnt;
  logic [DATA_W-1:0]   fill [N];
  logic [IDX_W-1:0]    close_idx;
  logic [N-1:0]        mask;
  logic [N*DATA_W-1:0] row;
  logic                xfer, close;
`ifdef CAUSAL_MASK_EN
  logic [IDX_W-1:0]    row_idx;
`endif
  assign in_ready  = en;
  assign xfer      = in_valid & en;
  assign close_idx = fill_cnt[IDX_W-1:0];
  assign close     = xfer & (in_last | (fill_cnt == CNT_W'(N - 1)));
  softmax_row_packer_lane_mask #(.N(N)) u_mask (
    .close_idx(close_idx),
`ifdef CAUSAL_MASK_EN
    .row_idx(row_idx),
`endif
    .mask(mask)
  );
  // the closing score bypasses the fill buffer so the row is complete on the same edge
  for (genvar k = 0; k < N; k++) begin : g_row
    assign row[k*DATA_W +: DATA_W] = mask[k] ? NEG_MIN
                                   : (IDX_W'(k) == close_idx) ? in_data : fill[k];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt   <= '0;
      for (int i = 0; i < N; i++) fill[i] <= '0;
      out_x_flat <= '0;
      valid_out  <= 1'b0;
      err_len    <= 1'b0;
`ifdef CAUSAL_MASK_EN
      row_idx    <= '0;
`endif
    end else if (en) begin
      valid_out <= close;
      if (xfer) begin
        fill[close_idx] <= in_data;
        fill_cnt        <= close ? '0 : fill_cnt + 1'b1;
      end
      if (close) begin
        out_x_flat <= row;
        err_len    <= err_len | ~in_last;
`ifdef CAUSAL_MASK_EN
        row_idx    <= (row_idx == IDX_W'(N - 1)) ? '0 : row_idx + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_softmax_row_packer.sv
// tb_softmax_row_packer: randomized scoreboard bench for softmax_row_packer
module tb_softmax_row_packer;
  localparam int N = 8;
  localparam int W = 16;
  logic clk = 0, rst = 0, en = 1, in_valid = 0, in_last = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, valid_out, err_len;
  logic [N*W-1:0] out_x_flat;
  always #5 clk = ~clk;
  softmax_row_packer #(.N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .valid_out(valid_out),
    .out_x_flat(out_x_flat), .err_len(err_len)
  );
  int checks = 0, failures = 0;
  logic [N*W-1:0] exp_q[$];
  logic [W-1:0] mbuf [N];
  logic [N*W-1:0] mvec;
  int mcnt = 0, mrow = 0;
  bit exp_pulse = 0, exp_err = 0, rnd_en = 0;
  function automatic bit causal_ok(input int k, input int r);
`ifdef CAUSAL_MASK_EN
    return k <= r;
`else
    return 1'b1;
`endif
  endfunction
  // reference model: rows as arrays of accepted scores, padded to N lanes on close
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt = 0; mrow = 0; exp_pulse = 0; exp_err = 0;
    end else if (en) begin
      exp_pulse = 0;
      if (in_valid) begin
        mbuf[mcnt] = in_data;
        if (in_last || mcnt == N - 1) begin
          for (int k = 0; k < N; k++)
            mvec[k*W +: W] = (k <= mcnt && causal_ok(k, mrow)) ? mbuf[k] : 16'h8000;
          exp_q.push_back(mvec);
          exp_pulse = 1;
          if (!in_last) exp_err = 1;
          mcnt = 0;
          mrow = (mrow + 1) % N;
        end else mcnt++;
      end
    end
  end
  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask
  task automatic chkv(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      chk1("in_ready", in_ready, en);
      chk1("valid_out", valid_out, exp_pulse);
      chk1("err_len", err_len, exp_err);
      if (valid_out && en) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL row_unexpected actual=%h required=none t=%0t", out_x_flat, $time);
        end else chkv("row", out_x_flat, exp_q.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [W-1:0] d, input bit l);
    int n = 0;
    bit done = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (!done) begin
      if (rnd_en) en = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      done = en;
      #1;
      n++;
      if (!done && n > 200) begin
        checks++; failures++;
        $display("FAIL send_timeout actual=stalled required=transfer t=%0t", $time);
        done = 1;
      end
    end
    in_valid = 0; in_last = 0; in_data = 16'($urandom);
  endtask
  task automatic do_reset();
    rst = 0;
    tick();
    chk1("rst_valid", valid_out, 1'b0);
    chk1("rst_err", err_len, 1'b0);
    chkv("rst_flat", out_x_flat, '0);
    tick();
    rst = 1;
    tick();
  endtask
  initial begin
    #1;
    do_reset();
    for (int i = 1; i <= N; i++) send(16'(i), i == N);
    tick(); tick();
    send(16'd5, 0); send(16'hFFFE, 0); send(16'd7, 1);
    tick();
    for (int i = 0; i < 2 * N; i++) send(16'(i * 3 + 1), i == 2 * N - 1);
    tick();
    send(16'h0011, 0); send(16'h0022, 0);
    en = 0; in_valid = 1; in_data = 16'h7777;
    tick(); tick(); tick();
    in_valid = 0; en = 1;
    send(16'h0033, 0); send(16'h0044, 1);
    en = 0;
    tick(); tick(); tick();
    en = 1;
    tick(); tick();
    for (int i = 0; i < 4; i++) send(16'h0AA0 + 16'(i), 0);
    do_reset();
    for (int i = 0; i < N; i++) send(16'h0B00 + 16'(i), i == N - 1);
    tick();
    do_reset();
    for (int r = 0; r < N + 1; r++)
      for (int i = 0; i < N; i++) send(16'h0100, i == N - 1);
    tick();
    rnd_en = 1;
    for (int r = 0; r < 200; r++) begin
      int len;
      bit nolast;
      len = $urandom_range(1, N);
      nolast = (len == N) && ($urandom_range(0, 1) == 1);
      for (int j = 0; j < len; j++) begin
        send(16'($urandom), (j == len - 1) && !nolast);
        if ($urandom_range(0, 4) == 0) tick();
      end
    end
    rnd_en = 0; en = 1;
    tick(); tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rows_missing actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
